// File: rtl/instr_fetch_stage.sv
`timescale 1ns/1ps
// instr_fetch_stage: IF stage owning the PC, fetching over imem req/rdy.
// Build option IF_PERF_CNT_EN adds fetch_cnt / fetch_wait_cnt outputs.
module instr_fetch_stage #(
    parameter int              PC_W     = 22,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               hlt,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_PC,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IF_instr,
    output logic [PC_W-1:0]    IF_PC,
    output logic               IF_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        fetch_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      drain_q, drain_d;
    logic [PC_W-1:0]      ipc_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 valid_q;
    logic                 load;
    logic                 accept;

    assign accept = valid_q & ~stall & ~hlt & ~flush;

    // State, PC and drain-address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
        end
    end

    // Next state: flush redirects first, otherwise advance on handshakes
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drain_d = drain_q;
        load    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (flush) begin
                    pc_d = redirect_PC;
                    if (!imem_rdy) begin
                        drain_d = pc_q;
                        state_d = DRAIN;
                    end
                end else if (imem_rdy) begin
                    load    = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = VALID;
                end
            end
            VALID: begin
                if (flush) begin
                    pc_d = redirect_PC;
                    if (imem_req && !imem_rdy) begin
                        drain_d = pc_q;
                        state_d = DRAIN;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (accept) begin
                    if (imem_rdy) begin
                        load = 1'b1;
                        pc_d = pc_q + PC_W'(1);
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (flush) pc_d = redirect_PC;
                if (imem_rdy) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Request/address: the old address is replayed while draining
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        unique case (state_q)
            FETCH: imem_req = 1'b1;
            VALID: imem_req = ~stall & ~hlt;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_q;
            end
            default: imem_req = 1'b0;
        endcase
        if (rst) imem_req = 1'b0;
    end

    // IF/ID-facing registers; cleared to a bubble when nothing is held
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= imem_rdata;
            ipc_q   <= pc_q;
        end else if (state_d != VALID) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end
    end

    assign IF_instr = instr_q;
    assign IF_PC    = ipc_q;
    assign IF_valid = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] wait_cnt_q;

    // Consumed-instruction and memory-wait counters, frozen under hlt
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else if (!hlt) begin
            if (accept)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (imem_req && !imem_rdy)
                wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt      = fetch_cnt_q;
    assign fetch_wait_cnt = wait_cnt_q;
`endif

endmodule
